pmod_tdm_serdes: RTL and testbench



---
 rtl/pmod_audio_pkg.sv | 31 +++
 rtl/pmod_bick_gen.sv | 57 +++++
 rtl/pmod_tdm_serdes.sv | 110 +++++++++++
 tb/tb_pmod_tdm_serdes.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pmod_audio_pkg.sv
// Shared constants, types and helpers for the eurorack-pmod audio path.
package pmod_audio_pkg;

  // Legal slot counts per frame.
  localparam int unsigned ChI2s  = 2;
  localparam int unsigned ChTdm4 = 4;
  localparam int unsigned ChTdm8 = 8;

  // Legal BICK periods per slot.
  localparam int unsigned SlotBits16 = 16;
  localparam int unsigned SlotBits32 = 32;

  // Codec framing mode, consumed by the I2C init sequence.
  typedef enum logic [1:0] {
    ModeI2s,
    ModeTdm128,
    ModeTdm256
  } codec_mode_e;

  // BICK periods per frame.
  function automatic int unsigned frame_bits(input int unsigned channels,
                                             input int unsigned slot_bits);
    return channels * slot_bits;
  endfunction

  function automatic bit cfg_legal(input int unsigned channels, input int unsigned slot_bits);
    return (channels == ChI2s || channels == ChTdm4 || channels == ChTdm8) &&
           (slot_bits == SlotBits16 || slot_bits == SlotBits32);
  endfunction

endpackage

// File: rtl/pmod_bick_gen.sv
// BICK/LRCK generator: clk divider plus frame bit counter.
// fall_ev/rise_ev are combinational and flag the clk edge on which bick falls/rises.
module pmod_bick_gen
  import pmod_audio_pkg::*;
#(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned SLOT_BITS = 32,
  parameter int unsigned BICK_DIV  = 4
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  output logic                                            bick,
  output logic                                            lrck,
  output logic                                            fall_ev,
  output logic                                            rise_ev,
  output logic [$clog2(frame_bits(CHANNELS, SLOT_BITS))-1:0] bit_cnt
);

  localparam int unsigned Frame = frame_bits(CHANNELS, SLOT_BITS);
  localparam int unsigned CW    = $clog2(Frame);
  localparam int unsigned DW    = $clog2(BICK_DIV);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] bit_q, bit_d;
  logic          bick_q, lrck_q;

  // Next divider/bit counter state and edge events.
  always_comb begin
    fall_ev = (div_q == DW'(BICK_DIV - 1));
    rise_ev = (div_q == DW'(BICK_DIV / 2 - 1));
    div_d   = fall_ev ? '0 : div_q + DW'(1);
    bit_d   = bit_q;
    if (fall_ev) begin
      bit_d = (bit_q == CW'(Frame - 1)) ? '0 : bit_q + CW'(1);
    end
  end

  // Counters and registered clocks; lrck follows the new bit_cnt so it moves with bick fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q  <= '0;
      bit_q  <= '0;
      bick_q <= 1'b0;
      lrck_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bit_q  <= bit_d;
      bick_q <= (div_d >= DW'(BICK_DIV / 2));
      lrck_q <= (bit_d >= CW'(Frame / 2));
    end
  end

  assign bick    = bick_q;
  assign lrck    = lrck_q;
  assign bit_cnt = bit_q;

endmodule

// File: rtl/pmod_tdm_serdes.sv
// I2S/TDM serial port for the eurorack-pmod codec.
// Optional: define PMOD_TDM_LOOPBACK_EN to add a loopback input that feeds sdout back to RX.
// Period p carries data index (p-1) mod FRAME; the TX bit for the period about to start
// therefore has index equal to the current bit_cnt.
module pmod_tdm_serdes
  import pmod_audio_pkg::*;
#(
  parameter int unsigned W         = 16,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned SLOT_BITS = 32,
  parameter int unsigned BICK_DIV  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef PMOD_TDM_LOOPBACK_EN
  input  logic                  loopback,
`endif
  input  logic [CHANNELS*W-1:0] sample_in,
  output logic [CHANNELS*W-1:0] sample_out,
  output logic                  frame_strobe,
  output logic                  bick,
  output logic                  lrck,
  output logic                  sdout,
  input  logic                  sdin
);

  localparam int unsigned Frame = frame_bits(CHANNELS, SLOT_BITS);
  localparam int unsigned CW    = $clog2(Frame);
  localparam int unsigned NB    = CHANNELS * W;
  localparam int unsigned IW    = $clog2(NB);

  logic          fall_ev, rise_ev;
  logic [CW-1:0] bit_cnt;

  logic [NB-1:0] shadow_q, rx_q, rx_d, sample_out_q, tx_src;
  logic          sdout_q, strobe_q, armed_q;
  logic          frame_ev, load, tx_bit, rx_bit;
  logic [IW-1:0] tx_pos, rx_pos;
  int unsigned   tx_idx, tx_b, rx_idx, rx_b;

  pmod_bick_gen #(
    .CHANNELS (CHANNELS),
    .SLOT_BITS(SLOT_BITS),
    .BICK_DIV (BICK_DIV)
  ) u_bick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .bick   (bick),
    .lrck   (lrck),
    .fall_ev(fall_ev),
    .rise_ev(rise_ev),
    .bit_cnt(bit_cnt)
  );

  // TX bit selection, RX bit placement and frame event decode.
  always_comb begin
    frame_ev = fall_ev && (bit_cnt == '0);
    // Frame 0 is a warm-up frame: nothing is latched or presented.
    load     = frame_ev && armed_q;
    // Slot 0 MSB goes out on the same edge sample_in is latched, so bypass the shadow.
    tx_src   = load ? sample_in : shadow_q;
    tx_idx   = 32'(bit_cnt);
    tx_b     = tx_idx % SLOT_BITS;
    tx_pos   = (tx_b < W) ? IW'((tx_idx / SLOT_BITS) * W + (W - 1 - tx_b)) : '0;
    tx_bit   = (tx_b < W) ? tx_src[tx_pos] : 1'b0;

    rx_idx   = (bit_cnt == '0) ? Frame - 1 : 32'(bit_cnt) - 1;
    rx_b     = rx_idx % SLOT_BITS;
    rx_pos   = (rx_b < W) ? IW'((rx_idx / SLOT_BITS) * W + (W - 1 - rx_b)) : '0;
`ifdef PMOD_TDM_LOOPBACK_EN
    rx_bit   = loopback ? sdout_q : sdin;
`else
    rx_bit   = sdin;
`endif
    rx_d     = rx_q;
    if (rise_ev && (rx_b < W)) begin
      rx_d[rx_pos] = rx_bit;
    end
  end

  // Datapath registers; RX buffer is complete before the load since rise precedes fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q     <= '0;
      rx_q         <= '0;
      sample_out_q <= '0;
      sdout_q      <= 1'b0;
      strobe_q     <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      rx_q     <= rx_d;
      strobe_q <= load;
      if (fall_ev) begin
        sdout_q <= tx_bit;
      end
      if (fall_ev && (bit_cnt == CW'(Frame - 1))) begin
        armed_q <= 1'b1;
      end
      if (load) begin
        shadow_q     <= sample_in;
        sample_out_q <= rx_q;
      end
    end
  end

  assign sample_out   = sample_out_q;
  assign frame_strobe = strobe_q;
  assign sdout        = sdout_q;

endmodule

// File: tb/tb_pmod_tdm_serdes.sv
// Directed bench: DUT A in default TDM4 config, DUT B in I2S config with SLOT_BITS==W.
`timescale 1ns/1ps
module tb_pmod_tdm_serdes;

  localparam int WA = 16, CHA = 4, SLA = 32, DVA = 4;
  localparam logic [63:0] Pat1 = 64'h7FFF_8000_0001_FFFF;
  localparam logic [63:0] Pat2 = 64'h1357_2468_DEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [63:0] sin_a, sout_a;
  logic        fs_a, bick_a, lrck_a, sdo_a, sdi_a;
  logic [31:0] sin_b, sout_b;
  logic        fs_b, bick_b, lrck_b, sdo_b, ext_b;
  wire         sdi_b;
  logic        lb_a, lb_b;

  int checks = 0;
  int failures = 0;

  logic txb [256];
  logic bb  [64];

  // External wire loop for DUT B; when broken, sdin is held high.
  assign sdi_b = ext_b ? sdo_b : 1'b1;

  pmod_tdm_serdes #(
    .W(WA), .CHANNELS(CHA), .SLOT_BITS(SLA), .BICK_DIV(DVA)
  ) dut_a (
    .clk         (clk),
    .rst_n       (rst_a),
`ifdef PMOD_TDM_LOOPBACK_EN
    .loopback    (lb_a),
`endif
    .sample_in   (sin_a),
    .sample_out  (sout_a),
    .frame_strobe(fs_a),
    .bick        (bick_a),
    .lrck        (lrck_a),
    .sdout       (sdo_a),
    .sdin        (sdi_a)
  );

  pmod_tdm_serdes #(
    .W(16), .CHANNELS(2), .SLOT_BITS(16), .BICK_DIV(4)
  ) dut_b (
    .clk         (clk),
    .rst_n       (rst_b),
`ifdef PMOD_TDM_LOOPBACK_EN
    .loopback    (lb_b),
`endif
    .sample_in   (sin_b),
    .sample_out  (sout_b),
    .frame_strobe(fs_b),
    .bick        (bick_b),
    .lrck        (lrck_b),
    .sdout       (sdo_b),
    .sdin        (sdi_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Codec model for DUT A: state cycle c lies in BICK period c/4.
  function automatic logic rx_model(input int c);
    int p, idx0, df, idx, slot, b;
    logic [63:0] pat;
    p = c / DVA;
    if (p == 0) return 1'b0;
    idx0 = p - 1;
    df   = idx0 / (CHA * SLA);
    idx  = idx0 % (CHA * SLA);
    slot = idx / SLA;
    b    = idx % SLA;
    pat  = (df >= 1) ? Pat2 : Pat1;
    if (b >= WA) return 1'b0;
    return pat[6'(slot * WA + WA - 1 - b)];
  endfunction

  function automatic logic [15:0] word_a(input int first);
    logic [15:0] w = '0;
    for (int i = 0; i < 16; i++) w = {w[14:0], txb[8'(first + i)]};
    return w;
  endfunction

  function automatic logic [15:0] word_b(input int first);
    logic [15:0] w = '0;
    for (int i = 0; i < 16; i++) w = {w[14:0], bb[6'(first + i)]};
    return w;
  endfunction

  task automatic wait_strobe_b(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (fs_b) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("strobe_b_wait", 64'(ok), 64'd1);
  endtask

  initial begin
    logic [7:0] bick_seq;
    logic       tx0_or;
    int         stray;
    logic [31:0] prev;
    bit          ok;

    rst_a = 1'b0; rst_b = 1'b0; ext_b = 1'b1; lb_a = 1'b0; lb_b = 1'b0;
    sin_a = 64'h8001_00FF_1234_A5A5;
    sin_b = {16'h8001, 16'h4002};
    sdi_a = 1'b0;
    bick_seq = '0; tx0_or = 1'b0; stray = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_bick", 64'(bick_a), 64'd0);
    check_eq("rst_lrck", 64'(lrck_a), 64'd0);
    check_eq("rst_sdout", 64'(sdo_a), 64'd0);
    check_eq("rst_strobe", 64'(fs_a), 64'd0);
    check_eq("rst_sample_out", sout_a, 64'd0);

    // DUT A: TDM4, frames of 512 clk.
    rst_a = 1'b1;
    for (int c = 0; c <= 1304; c++) begin
      if (c > 0) @(negedge clk);
      if (c < 8) bick_seq[c[2:0]] = bick_a;
      if (c < 512) tx0_or = tx0_or | sdo_a;
      if (c == 255) check_eq("lrck_255", 64'(lrck_a), 64'd0);
      if (c == 256) check_eq("lrck_256", 64'(lrck_a), 64'd1);
      if (c == 511) check_eq("lrck_511", 64'(lrck_a), 64'd1);
      if (c == 512) check_eq("lrck_512", 64'(lrck_a), 64'd0);
      if (fs_a && c != 516 && c != 1028) stray++;
      if (c == 515) check_eq("rx_before_first", sout_a, 64'd0);
      if (c == 516) begin
        check_eq("first_strobe_516", 64'(fs_a), 64'd1);
        check_eq("rx_frame0", sout_a, Pat1);
      end
      if (c == 530) sin_a = 64'h1111_2222_3333_C3C3;
      if (c == 1027) check_eq("rx_hold", sout_a, Pat1);
      if (c == 1028) begin
        check_eq("strobe_1028", 64'(fs_a), 64'd1);
        check_eq("rx_frame1", sout_a, Pat2);
      end
      if ((c % 4 == 1) && c >= 513 && c <= 1093) txb[8'(c / 4 - 128)] = sdo_a;
      if (c == 1304) check_eq("lrck_p70", 64'(lrck_a), 64'd1);
      sdi_a = rx_model(c);
    end
    check_eq("bick_wave", 64'(bick_seq), 64'hCC);
    check_eq("tx_frame0_zero", 64'(tx0_or), 64'd0);
    check_eq("no_stray_strobe", 64'(stray), 64'd0);
    check_eq("tx_slot0", 64'(word_a(1)), 64'hA5A5);
    check_eq("tx_pad0", 64'(word_a(17)), 64'h0);
    check_eq("tx_slot1", 64'(word_a(33)), 64'h1234);
    check_eq("tx_pad1", 64'(word_a(49)), 64'h0);
    check_eq("tx_slot2", 64'(word_a(65)), 64'h00FF);
    check_eq("tx_slot3", 64'(word_a(97)), 64'h8001);
    check_eq("tx_pad3_p0", 64'(word_a(113)), 64'h0);
    check_eq("tx_next_frame", 64'(word_a(129)), 64'hC3C3);

    // Mid-frame reset at period 70 of frame 2.
    rst_a = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_bick", 64'(bick_a), 64'd0);
    check_eq("mid_rst_lrck", 64'(lrck_a), 64'd0);
    check_eq("mid_rst_sdout", 64'(sdo_a), 64'd0);
    check_eq("mid_rst_strobe", 64'(fs_a), 64'd0);
    check_eq("mid_rst_sample_out", sout_a, 64'd0);
    rst_a = 1'b1;
    stray = 0;
    for (int c = 0; c <= 516; c++) begin
      if (c > 0) @(negedge clk);
      if (fs_a && c != 516) stray++;
      if (c == 515) check_eq("rerst_rx_zero", sout_a, 64'd0);
      if (c == 516) begin
        check_eq("rerst_strobe_516", 64'(fs_a), 64'd1);
        check_eq("rerst_rx_frame0", sout_a, Pat1);
      end
      sdi_a = rx_model(c);
    end
    check_eq("rerst_no_stray", 64'(stray), 64'd0);
    rst_a = 1'b0;

    // DUT B: I2S, SLOT_BITS == W, frames of 128 clk, sdout wired to sdin.
    stray = 0;
    rst_b = 1'b1;
    for (int c = 0; c <= 390; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 129) check_eq("i2s_p0_old_shadow", 64'(sdo_b), 64'd0);
      if (fs_b && c != 132 && c != 260 && c != 388) stray++;
      if (c == 132) begin
        check_eq("i2s_strobe_132", 64'(fs_b), 64'd1);
        check_eq("i2s_rx_frame0", 64'(sout_b), 64'd0);
      end
      if (c == 200) sin_b = {16'h8000, 16'h4002};
      if ((c % 4 == 1) && c >= 129 && c <= 257) bb[6'(c / 4 - 32)] = sdo_b;
      if (c == 260) begin
        check_eq("i2s_strobe_260", 64'(fs_b), 64'd1);
        check_eq("i2s_rx_frame1", 64'(sout_b), 64'h8001_4002);
      end
      if (c == 388) check_eq("i2s_rx_frame2", 64'(sout_b), 64'h8000_4002);
    end
    check_eq("i2s_no_stray", 64'(stray), 64'd0);
    check_eq("i2s_left", 64'(word_b(1)), 64'h4002);
    check_eq("i2s_right", 64'(word_b(17)), 64'h8001);
    check_eq("i2s_right_lsb_p0", 64'(bb[6'(32)]), 64'd1);

`ifdef PMOD_TDM_LOOPBACK_EN
    // Internal loopback with sdin held high: ramp must come back one frame late.
    rst_b = 1'b0;
    @(negedge clk);
    lb_b = 1'b1; ext_b = 1'b0;
    sin_b = 32'h0000_0008;
    prev = '0;
    rst_b = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_strobe_b(200, ok);
      if (!ok) break;
      check_eq($sformatf("loopback_%0d", k), 64'(sout_b), 64'(prev));
      prev = sin_b;
      sin_b = sin_b + 32'd8;
    end
`else
    prev = '0;
    ok = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
